if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction inserted into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hazard unit hold request; IF/ID and PC hold.
REQ-006 flush  input  1  kill the instruction currently being fetched.
REQ-007 branch_taken  input  1  EX-stage redirect (branch/jal/jalr resolved).
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, word aligned.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 imem_ready  input  1  imem_rdata valid this cycle for imem_addr.
REQ-013 if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-014 if_id_instr  output  32  instruction held in IF/ID; feeds decode and immediate generation.
REQ-015 if_id_opcode  output  7  always equal to if_id_instr[6:0].
REQ-016 if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.

Function
REQ-017 State machine: BOOT (entered on reset) and RUN; BOOT -> RUN unconditionally on the first clock edge after rst deasserts; RUN stays in RUN until reset.
REQ-018 imem_req SHALL be 0 in BOOT and 1 in RUN.
REQ-019 imem_addr SHALL equal the PC register combinationally, with bits [1:0] always 0.
REQ-020 A fetch completes in a RUN cycle with imem_req=1 and imem_ready=1; zero added latency: the word is captured into IF/ID at that edge.
REQ-021 Per-edge priority in RUN: (1) branch_taken, (2) flush, (3) stall, (4) fetch complete, (5) memory wait.
REQ-022 branch_taken=1: PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble; regardless of stall, flush, or imem_ready.
REQ-023 flush=1, branch_taken=0: PC holds; IF/ID <= bubble.
REQ-024 stall=1, no branch/flush: PC and all IF/ID outputs hold their values, including if_id_valid; completed imem data is discarded and refetched.
REQ-025 Fetch complete, no stall/flush/branch: IF/ID <= {PC, imem_rdata, valid=1}; PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-026 imem_ready=0, no stall/flush/branch: PC holds; IF/ID <= bubble.
REQ-027 Bubble SHALL be if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=PC of the cycle in which the bubble was inserted.
REQ-028 In BOOT, PC and IF/ID SHALL hold their reset values regardless of inputs.

Reset
REQ-029 While rst=1, asynchronously: state=BOOT, PC=RESET_PC, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_valid=0, imem_req=0.
REQ-030 Reset asserted mid-fetch or mid-stall SHALL discard all in-progress state with no partial update.

Verification
REQ-031 Reset release, imem_ready=1 always, imem_rdata=addr-derived words -> imem_req 0 for one cycle, then if_id_pc 0,4,8,... with valid=1 on consecutive cycles.
REQ-032 stall=1 for 3 cycles after PC=0x10 captured -> if_id_pc stays 0x10, imem_addr stays 0x14; the next fetch after release captures 0x14.
REQ-033 branch_taken=1, branch_target=0x0000_0203, with stall=1 and imem_ready=0 -> next cycle imem_addr=0x200, if_id_valid=0, if_id_instr=0x00000013.
REQ-034 imem_ready=0 for 2 cycles at PC=0x40 -> two bubbles, PC holds 0x40; on ready, IF/ID captures pc 0x40 with valid=1.
REQ-035 flush=1 with imem_ready=1 at PC=0x80 -> IF/ID bubble, next imem_addr=0x80.
REQ-036 RESET_PC=0xFFFF_FFFC, ready=1 -> captures pc 0xFFFF_FFFC, then imem_addr=0x0000_0000; if_id_opcode tracks if_id_instr[6:0] throughout.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencer and the IF/ID pipeline register.
// A fetch that completes (imem_ready) is captured into IF/ID at the same edge.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic        if_id_valid
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  state_t      state;
  logic [31:0] pc;
  ifid_t       ifid;

  assign imem_addr    = {pc[31:2], 2'b00};
  assign if_id_pc     = ifid.pc;
  assign if_id_instr  = ifid.instr;
  assign if_id_opcode = ifid.instr[6:0];
  assign if_id_valid  = ifid.valid;

  // Priority: redirect > flush > stall > completed fetch > memory wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      imem_req <= 1'b0;
      pc       <= RESET_PC;
      ifid     <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    end else if (state == BOOT) begin
      state    <= RUN;
      imem_req <= 1'b1;
    end else begin
      imem_req <= 1'b1;
      if (branch_taken) begin
        pc   <= {branch_target[31:2], 2'b00};
        ifid <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
      end else if (flush) begin
        ifid <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
      end else if (!stall) begin
        if (imem_ready) begin
          ifid <= '{pc: pc, instr: imem_rdata, valid: 1'b1};
          pc   <= pc + 32'd4;
        end else begin
          ifid <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, mid-stall reset, PC wrap instance,
// then randomized traffic against a rule-level reference model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, stall, flush, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata, imem_rdata2;
  logic        imem_req, imem_req2, if_id_valid, if_id_valid2;
  logic [31:0] imem_addr, imem_addr2, if_id_pc, if_id_pc2, if_id_instr, if_id_instr2;
  logic [6:0]  if_id_opcode, if_id_opcode2;

  int total = 0;
  int passed = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata  = w(imem_addr);
  assign imem_rdata2 = w(imem_addr2);

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_opcode(if_id_opcode), .if_id_valid(if_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .imem_ready(imem_ready), .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
    .if_id_opcode(if_id_opcode2), .if_id_valid(if_id_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] ipc, input logic vld, input logic [31:0] instr);
    chk({tag, ".req"},    {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"},   imem_addr, addr);
    chk({tag, ".pc"},     if_id_pc, ipc);
    chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, vld});
    chk({tag, ".instr"},  if_id_instr, instr);
    chk({tag, ".opcode"}, {25'd0, if_id_opcode}, {25'd0, instr[6:0]});
  endtask

  typedef struct {
    logic        stall, flush, br;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] addr, ipc;
    logic        valid;
  } vec_t;

  vec_t tbl[18];

  longint unsigned m_pc, m_ipc;
  logic [31:0]     m_instr;
  logic            m_valid, m_run;

  initial begin
    tbl[0]  = '{0, 0, 0, 32'h0,   1, 32'h00,  32'h00,  0};  // BOOT edge
    tbl[1]  = '{0, 0, 0, 32'h0,   1, 32'h04,  32'h00,  1};
    tbl[2]  = '{0, 0, 0, 32'h0,   1, 32'h08,  32'h04,  1};
    tbl[3]  = '{0, 0, 0, 32'h0,   1, 32'h0C,  32'h08,  1};
    tbl[4]  = '{0, 0, 0, 32'h0,   1, 32'h10,  32'h0C,  1};
    tbl[5]  = '{0, 0, 0, 32'h0,   1, 32'h14,  32'h10,  1};
    tbl[6]  = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h10,  1};
    tbl[7]  = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h10,  1};
    tbl[8]  = '{1, 0, 0, 32'h0,   1, 32'h14,  32'h10,  1};
    tbl[9]  = '{0, 0, 0, 32'h0,   1, 32'h18,  32'h14,  1};
    tbl[10] = '{1, 0, 1, 32'h203, 0, 32'h200, 32'h18,  0};
    tbl[11] = '{0, 0, 1, 32'h40,  1, 32'h40,  32'h200, 0};
    tbl[12] = '{0, 0, 0, 32'h0,   0, 32'h40,  32'h40,  0};
    tbl[13] = '{0, 0, 0, 32'h0,   0, 32'h40,  32'h40,  0};
    tbl[14] = '{0, 0, 0, 32'h0,   1, 32'h44,  32'h40,  1};
    tbl[15] = '{0, 0, 1, 32'h80,  1, 32'h80,  32'h44,  0};
    tbl[16] = '{0, 1, 0, 32'h0,   1, 32'h80,  32'h80,  0};
    tbl[17] = '{0, 0, 0, 32'h0,   1, 32'h84,  32'h80,  1};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, NOP);
    chk("reset2.addr", imem_addr2, 32'hFFFF_FFFC);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      stall = tbl[i].stall; flush = tbl[i].flush; branch_taken = tbl[i].br;
      branch_target = tbl[i].tgt; imem_ready = tbl[i].ready;
      step();
      chk_all($sformatf("vec%0d", i), 1'b1, tbl[i].addr, tbl[i].ipc, tbl[i].valid,
              tbl[i].valid ? w(tbl[i].ipc) : NOP);
      if (i == 0) chk("wrap.boot_addr", imem_addr2, 32'hFFFF_FFFC);
      if (i == 1) begin
        chk("wrap.pc", if_id_pc2, 32'hFFFF_FFFC);
        chk("wrap.valid", {31'd0, if_id_valid2}, 32'd1);
        chk("wrap.addr", imem_addr2, 32'h0);
        chk("wrap.opcode", {25'd0, if_id_opcode2}, {25'd0, w(32'hFFFF_FFFC) & 32'h7F});
      end
      if (i == 2) chk("wrap.next_pc", if_id_pc2, 32'h0);
    end

    // Reset asserted mid-stall, between edges: must clear immediately.
    stall = 1'b1; imem_ready = 1'b1; branch_taken = 1'b0; flush = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk_all("midrst", 1'b0, 32'h0, 32'h0, 1'b0, NOP);
    step();
    rst = 1'b0; stall = 1'b0;

    m_run = 1'b0; m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                  : $urandom;
      imem_ready    = ($urandom_range(0, 9) < 7);
      if (!m_run) m_run = 1'b1;
      else if (branch_taken) begin
        m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
        m_pc = longint'(branch_target) - (longint'(branch_target) % 4);
      end else if (flush) begin
        m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
      end else if (stall) begin
        // everything holds
      end else if (imem_ready) begin
        m_ipc = m_pc; m_instr = w(32'(m_pc)); m_valid = 1'b1;
        m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end else begin
        m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
      end
      step();
      chk_all($sformatf("rnd%0d", n), 1'b1, 32'(m_pc), 32'(m_ipc), m_valid, m_instr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
